riscv: RTL and testbench

Single-cycle RV32I integer core datapath with its control unit. The instruction word is supplied externally on `I`; there is no instruction memory inside the block. The block contains the PC, a 32×32 register file, immediate generator, branch comparator, ALU and a 64-word data memory. Every control signal and major datapath node is exported as an output port for bench observation.

---
 rtl/riscv.sv | 249 ++++++++++++++++++++++++
 tb/tb_riscv.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv.sv
// Single-cycle RV32I core: PC, 32x32 register file, immediate generator,
// branch comparator, ALU and 64-word data memory. The instruction arrives on I each cycle.
module riscv (
    input  logic        clk,
    input  logic        resetReg,
    input  logic [31:0] I,
    output logic [31:0] PCVal,
    output logic [31:0] rs1Out,
    output logic [31:0] rs2Out,
    output logic [31:0] signExtendedVal,
    output logic [31:0] ALUin1,
    output logic [31:0] ALUin2,
    output logic [31:0] ALUresult,
    output logic [31:0] RegDataIn,
    output logic        writeEnable,
    output logic        BrEq,
    output logic        BrLt,
    output logic        BrUn,
    output logic        ASel,
    output logic        BSel,
    output logic [2:0]  ImmSel,
    output logic [3:0]  ALUop,
    output logic [1:0]  WBSel,
    output logic        PCSel,
    output logic        MemRW
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7b5;

    logic [31:0]       pc_q, pc_d, pc_plus4;
    logic [31:0][31:0] regs_q, regs_d;
    logic [63:0][31:0] mem_q, mem_d;
    logic [31:0]       mem_rdata;
    logic              is_jalr;
    logic              br_taken;

    assign opcode   = I[6:0];
    assign rd       = I[11:7];
    assign funct3   = I[14:12];
    assign rs1      = I[19:15];
    assign rs2      = I[24:20];
    assign funct7b5 = I[30];

    assign PCVal    = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

    assign rs1Out = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2Out = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    // OP and OP-IMM share the funct3 map; alt selects SUB/SRA
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    assign BrUn = (opcode == OPC_BRANCH) && (funct3[2:1] == 2'b11);
    assign BrEq = (rs1Out == rs2Out);
    assign BrLt = BrUn ? (rs1Out < rs2Out) : ($signed(rs1Out) < $signed(rs2Out));

    always_comb begin
        case (funct3)
            3'b000:         br_taken = BrEq;
            3'b001:         br_taken = !BrEq;
            3'b100, 3'b110: br_taken = BrLt;
            3'b101, 3'b111: br_taken = !BrLt;
            default:        br_taken = 1'b0;
        endcase
    end

    always_comb begin
        writeEnable = 1'b0;
        ASel        = 1'b0;
        BSel        = 1'b0;
        ImmSel      = IMM_I;
        ALUop       = ALU_ADD;
        WBSel       = WB_MEM;
        PCSel       = 1'b0;
        MemRW       = 1'b0;
        is_jalr     = 1'b0;
        case (opcode)
            OPC_OP: begin
                writeEnable = 1'b1;
                WBSel       = WB_ALU;
                ALUop       = alu_sel(funct3, funct7b5);
            end
            OPC_OPIMM: begin
                writeEnable = 1'b1;
                BSel        = 1'b1;
                WBSel       = WB_ALU;
                ALUop       = alu_sel(funct3, (funct3 == 3'b101) && funct7b5);
            end
            OPC_LUI: begin
                writeEnable = 1'b1;
                BSel        = 1'b1;
                ImmSel      = IMM_U;
                ALUop       = ALU_PASSB;
                WBSel       = WB_ALU;
            end
            OPC_AUIPC: begin
                writeEnable = 1'b1;
                ASel        = 1'b1;
                BSel        = 1'b1;
                ImmSel      = IMM_U;
                WBSel       = WB_ALU;
            end
            OPC_LOAD: begin
                writeEnable = 1'b1;
                BSel        = 1'b1;
                WBSel       = WB_MEM;
            end
            OPC_STORE: begin
                BSel   = 1'b1;
                ImmSel = IMM_S;
                MemRW  = 1'b1;
            end
            OPC_BRANCH: begin
                ASel   = 1'b1;
                BSel   = 1'b1;
                ImmSel = IMM_B;
                PCSel  = br_taken;
            end
            OPC_JAL: begin
                writeEnable = 1'b1;
                ASel        = 1'b1;
                BSel        = 1'b1;
                ImmSel      = IMM_J;
                WBSel       = WB_PC4;
                PCSel       = 1'b1;
            end
            OPC_JALR: begin
                writeEnable = 1'b1;
                BSel        = 1'b1;
                WBSel       = WB_PC4;
                PCSel       = 1'b1;
                is_jalr     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ImmSel)
            IMM_I:   signExtendedVal = {{20{I[31]}}, I[31:20]};
            IMM_S:   signExtendedVal = {{20{I[31]}}, I[31:25], I[11:7]};
            IMM_B:   signExtendedVal = {{19{I[31]}}, I[31], I[7], I[30:25], I[11:8], 1'b0};
            IMM_U:   signExtendedVal = {I[31:12], 12'b0};
            IMM_J:   signExtendedVal = {{11{I[31]}}, I[31], I[19:12], I[20], I[30:21], 1'b0};
            default: signExtendedVal = 32'd0;
        endcase
    end

    assign ALUin1 = ASel ? pc_q : rs1Out;
    assign ALUin2 = BSel ? signExtendedVal : rs2Out;

    always_comb begin
        case (ALUop)
            ALU_ADD:   ALUresult = ALUin1 + ALUin2;
            ALU_SUB:   ALUresult = ALUin1 - ALUin2;
            ALU_SLL:   ALUresult = ALUin1 << ALUin2[4:0];
            ALU_SLT:   ALUresult = {31'd0, $signed(ALUin1) < $signed(ALUin2)};
            ALU_SLTU:  ALUresult = {31'd0, ALUin1 < ALUin2};
            ALU_XOR:   ALUresult = ALUin1 ^ ALUin2;
            ALU_SRL:   ALUresult = ALUin1 >> ALUin2[4:0];
            ALU_SRA:   ALUresult = $unsigned($signed(ALUin1) >>> ALUin2[4:0]);
            ALU_OR:    ALUresult = ALUin1 | ALUin2;
            ALU_AND:   ALUresult = ALUin1 & ALUin2;
            ALU_PASSB: ALUresult = ALUin2;
            default:   ALUresult = 32'd0;
        endcase
    end

    // word-addressed memory: only bits [7:2] of the byte address select a word
    assign mem_rdata = mem_q[ALUresult[7:2]];

    always_comb begin
        case (WBSel)
            WB_MEM:  RegDataIn = mem_rdata;
            WB_ALU:  RegDataIn = ALUresult;
            WB_PC4:  RegDataIn = pc_plus4;
            default: RegDataIn = 32'd0;
        endcase
    end

    always_comb begin
        pc_d = pc_plus4;
        if (PCSel)
            pc_d = is_jalr ? {ALUresult[31:1], 1'b0} : ALUresult;
        regs_d = regs_q;
        if (writeEnable && (rd != 5'd0))
            regs_d[rd] = RegDataIn;
        mem_d = mem_q;
        if (MemRW)
            mem_d[ALUresult[7:2]] = rs2Out;
    end

    always_ff @(posedge clk) begin
        if (resetReg) begin
            pc_q   <= 32'd0;
            regs_q <= '0;
            mem_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            mem_q  <= mem_d;
        end
    end
endmodule

// File: tb/tb_riscv.sv
// Bench for the single-cycle RV32I core: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_riscv;
    logic        clk = 1'b0;
    logic        resetReg = 1'b0;
    logic [31:0] I = 32'h00000013;
    logic [31:0] PCVal, rs1Out, rs2Out, signExtendedVal, ALUin1, ALUin2, ALUresult, RegDataIn;
    logic        writeEnable, BrEq, BrLt, BrUn, ASel, BSel, PCSel, MemRW;
    logic [2:0]  ImmSel;
    logic [3:0]  ALUop;
    logic [1:0]  WBSel;

    riscv dut (
        .clk(clk), .resetReg(resetReg), .I(I), .PCVal(PCVal), .rs1Out(rs1Out), .rs2Out(rs2Out),
        .signExtendedVal(signExtendedVal), .ALUin1(ALUin1), .ALUin2(ALUin2), .ALUresult(ALUresult),
        .RegDataIn(RegDataIn), .writeEnable(writeEnable), .BrEq(BrEq), .BrLt(BrLt), .BrUn(BrUn),
        .ASel(ASel), .BSel(BSel), .ImmSel(ImmSel), .ALUop(ALUop), .WBSel(WBSel), .PCSel(PCSel),
        .MemRW(MemRW)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // architectural model state and the effect of the instruction currently presented
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [64];
    logic [31:0] m_pc;
    logic        e_we, e_st, cur_rst;
    logic [4:0]  e_rd;
    logic [5:0]  e_sa;
    logic [31:0] e_wd, e_npc, e_sd;

    localparam logic [31:0] NOP = 32'h00000013;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                          logic [2:0] f3, logic [4:0] rdx, logic [6:0] op);
        return {f7, r2, r1, f3, rdx, op};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rdx);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rdx, 7'h6F};
    endfunction

    function automatic logic [31:0] ref_op(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic void model_exec(logic [31:0] ins);
        logic [31:0] a, b, ii, is, ib, iu, ij, addr;
        logic [2:0]  f3;
        logic        tk;
        a  = m_regs[ins[19:15]];
        b  = m_regs[ins[24:20]];
        f3 = ins[14:12];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'd0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e_we = 1'b0; e_st = 1'b0; e_rd = ins[11:7]; e_wd = 32'd0;
        e_npc = m_pc + 32'd4; e_sa = 6'd0; e_sd = 32'd0;
        case (ins[6:0])
            7'h33: begin e_we = 1'b1; e_wd = ref_op(f3, ins[30], a, b); end
            7'h13: begin e_we = 1'b1; e_wd = ref_op(f3, (f3 == 3'd5) && ins[30], a, ii); end
            7'h37: begin e_we = 1'b1; e_wd = iu; end
            7'h17: begin e_we = 1'b1; e_wd = m_pc + iu; end
            7'h03: begin addr = a + ii; e_we = 1'b1; e_wd = m_mem[addr[7:2]]; end
            7'h23: begin addr = a + is; e_st = 1'b1; e_sa = addr[7:2]; e_sd = b; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = $signed(a) < $signed(b);
                    3'd5: tk = $signed(a) >= $signed(b);
                    3'd6: tk = a < b;
                    3'd7: tk = a >= b;
                    default: tk = 1'b0;
                endcase
                if (tk) e_npc = m_pc + ib;
            end
            7'h6F: begin e_we = 1'b1; e_wd = m_pc + 32'd4; e_npc = m_pc + ij; end
            7'h67: begin e_we = 1'b1; e_wd = m_pc + 32'd4; e_npc = (a + ii) & 32'hFFFFFFFE; end
            default: ;
        endcase
    endfunction

    task automatic setup(input logic [31:0] ins, input logic rst);
        @(negedge clk);
        I = ins; resetReg = rst; cur_rst = rst;
        #1;
        model_exec(ins);
    endtask

    task automatic advance();
        @(posedge clk);
        if (cur_rst) begin
            m_pc = 32'd0;
            for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
            for (int k = 0; k < 64; k++) m_mem[k] = 32'd0;
        end else begin
            if (e_we && e_rd != 5'd0) m_regs[e_rd] = e_wd;
            if (e_st) m_mem[e_sa] = e_sd;
            m_pc = e_npc;
        end
    endtask

    task automatic do_reset();
        setup(NOP, 1'b1);
        advance();
    endtask

    task automatic test_reset();
        do_reset();
        setup(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33), 1'b0);
        n_tests++; if (PCVal !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", PCVal); end
        n_tests++; if (rs1Out !== 32'd0 || rs2Out !== 32'd0) begin
            n_fail++; $display("FAIL reset_regs got %h/%h exp 0", rs1Out, rs2Out); end
        advance();
    endtask

    task automatic test_xori();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            setup(32'h0041C093, 1'b0);
            n_tests++; if (PCVal !== 32'd4 * c) begin n_fail++; $display("FAIL xori_pc%0d got %h exp %h", c, PCVal, 32'd4 * c); end
            if (c == 0) begin
                n_tests++;
                if ({ImmSel, BSel, ALUop, writeEnable} !== {3'd0, 1'b1, 4'd5, 1'b1}) begin
                    n_fail++; $display("FAIL xori_ctrl got imm=%0d b=%0d op=%0d we=%0d", ImmSel, BSel, ALUop, writeEnable); end
                n_tests++;
                if ({ALUin1, ALUin2, ALUresult, RegDataIn} !== {32'd0, 32'd4, 32'd4, 32'd4}) begin
                    n_fail++; $display("FAIL xori_data got %h %h %h %h", ALUin1, ALUin2, ALUresult, RegDataIn); end
            end
            advance();
        end
    endtask

    task automatic test_addi_hold();
        setup(32'h00C08093, 1'b0);
        n_tests++; if (rs1Out !== 32'd4) begin n_fail++; $display("FAIL addi_rs1_a got %h exp 4", rs1Out); end
        advance();
        setup(32'h00C08093, 1'b0);
        n_tests++; if (rs1Out !== 32'd16) begin n_fail++; $display("FAIL addi_rs1_b got %h exp 10", rs1Out); end
        advance();
        setup(enc_r(7'd0, 5'd0, 5'd1, 3'd0, 5'd0, 7'h33), 1'b0);
        n_tests++; if (rs1Out !== 32'd28) begin n_fail++; $display("FAIL addi_x1 got %h exp 1c", rs1Out); end
        advance();
    endtask

    task automatic test_alu();
        setup(32'h00500113, 1'b0); advance();
        setup(32'h00700193, 1'b0); advance();
        setup(32'h40310233, 1'b0);
        n_tests++; if (ALUresult !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub got %h exp fffffffe", ALUresult); end
        advance();
        setup(enc_r(7'd0, 5'd3, 5'd2, 3'd3, 5'd5, 7'h33), 1'b0);
        n_tests++; if (ALUresult !== 32'd1) begin n_fail++; $display("FAIL sltu got %h exp 1", ALUresult); end
        advance();
        setup(32'h80000337, 1'b0); advance();
        setup(32'h00400393, 1'b0); advance();
        setup(enc_r(7'h20, 5'd7, 5'd6, 3'd5, 5'd8, 7'h33), 1'b0);
        n_tests++; if (ALUresult !== 32'hF8000000) begin n_fail++; $display("FAIL sra got %h exp f8000000", ALUresult); end
        advance();
    endtask

    task automatic test_mem();
        setup(32'h00302423, 1'b0);
        n_tests++; if (MemRW !== 1'b1 || writeEnable !== 1'b0) begin
            n_fail++; $display("FAIL sw_ctrl got memrw=%0d we=%0d exp 1/0", MemRW, writeEnable); end
        advance();
        setup(32'h00802283, 1'b0);
        n_tests++; if (WBSel !== 2'd0 || RegDataIn !== 32'd7) begin
            n_fail++; $display("FAIL lw got wbsel=%0d data=%h exp 0/7", WBSel, RegDataIn); end
        advance();
    endtask

    task automatic test_branch();
        do_reset();
        for (int c = 0; c < 4; c++) begin setup(NOP, 1'b0); advance(); end
        setup(32'h00000463, 1'b0);
        n_tests++; if (PCVal !== 32'h10 || BrEq !== 1'b1 || PCSel !== 1'b1) begin
            n_fail++; $display("FAIL beq got pc=%h breq=%0d pcsel=%0d", PCVal, BrEq, PCSel); end
        advance();
        setup(enc_b(13'd8, 5'd0, 5'd0, 3'd1), 1'b0);
        n_tests++; if (PCVal !== 32'h18 || PCSel !== 1'b0) begin
            n_fail++; $display("FAIL bne got pc=%h pcsel=%0d exp 18/0", PCVal, PCSel); end
        advance();
        setup(enc_j(21'd16, 5'd1), 1'b0);
        n_tests++; if (PCVal !== 32'h1C || RegDataIn !== 32'h20) begin
            n_fail++; $display("FAIL jal got pc=%h rd=%h exp 1c/20", PCVal, RegDataIn); end
        advance();
        setup(enc_r(7'd0, 5'd0, 5'd1, 3'd0, 5'd0, 7'h33), 1'b0);
        n_tests++; if (PCVal !== 32'h2C || rs1Out !== 32'h20) begin
            n_fail++; $display("FAIL jal_after got pc=%h x1=%h exp 2c/20", PCVal, rs1Out); end
        advance();
    endtask

    task automatic test_x0_nop();
        setup(32'h00500013, 1'b0);
        n_tests++; if (RegDataIn !== 32'd5) begin n_fail++; $display("FAIL x0_wdata got %h exp 5", RegDataIn); end
        advance();
        setup(32'h00500013, 1'b0);
        n_tests++; if (rs1Out !== 32'd0) begin n_fail++; $display("FAIL x0_read got %h exp 0", rs1Out); end
        advance();
        setup(32'hFFFFFF8B, 1'b0);
        n_tests++;
        if ({writeEnable, MemRW, PCSel, ASel, BSel, BrUn, ImmSel, ALUop, WBSel} !== 14'd0) begin
            n_fail++; $display("FAIL nop_ctrl got we=%0d mem=%0d pcs=%0d a=%0d b=%0d un=%0d imm=%0d op=%0d wb=%0d",
                               writeEnable, MemRW, PCSel, ASel, BSel, BrUn, ImmSel, ALUop, WBSel); end
        advance();
        setup(NOP, 1'b0);
        n_tests++; if (PCVal !== m_pc) begin n_fail++; $display("FAIL nop_pc got %h exp %h", PCVal, m_pc); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] w;
        int bad;
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            case ($urandom_range(0, 12))
                0, 1: begin
                    w[6:0] = 7'h33;
                    w[31:25] = ((w[14:12] == 3'd0 || w[14:12] == 3'd5) && w[30]) ? 7'h20 : 7'h00;
                end
                2, 3: begin
                    w[6:0] = 7'h13;
                    if (w[14:12] == 3'd1) w[31:25] = 7'h00;
                    if (w[14:12] == 3'd5) w[31:25] = {1'b0, w[30], 5'd0};
                end
                4: w[6:0] = 7'h37;
                5: w[6:0] = 7'h17;
                6: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
                7, 8: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
                9, 10: begin w[6:0] = 7'h63; if (w[14:13] == 2'b01) w[14] = 1'b1; end
                11: w[6:0] = (w[7]) ? 7'h6F : 7'h0B;
                default: begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
            endcase
            setup(w, 1'b0);
            n_tests++;
            if (PCVal !== m_pc || rs1Out !== m_regs[w[19:15]] || rs2Out !== m_regs[w[24:20]] ||
                writeEnable !== e_we || MemRW !== e_st || (e_we && RegDataIn !== e_wd)) begin
                n_fail++; bad++;
                if (bad < 6)
                    $display("FAIL rand ins=%h pc=%h/%h rs1=%h/%h rs2=%h/%h we=%0d/%0d st=%0d/%0d wd=%h/%h",
                             w, PCVal, m_pc, rs1Out, m_regs[w[19:15]], rs2Out, m_regs[w[24:20]],
                             writeEnable, e_we, MemRW, e_st, RegDataIn, e_wd);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        setup(32'h07B00293, 1'b0); advance();
        setup(32'h00502823, 1'b1);
        advance();
        for (int r = 0; r < 32; r++) begin
            setup(enc_r(7'd0, 5'(31 - r), 5'(r), 3'd0, 5'd0, 7'h33), 1'b0);
            if (r == 0) begin
                n_tests++; if (PCVal !== 32'd0) begin n_fail++; $display("FAIL rstmid_pc got %h exp 0", PCVal); end
            end
            n_tests++; if (rs1Out !== 32'd0 || rs2Out !== 32'd0) begin
                n_fail++; $display("FAIL rstmid_reg%0d got %h/%h exp 0", r, rs1Out, rs2Out); end
            advance();
        end
        setup(32'h01002303, 1'b0);
        n_tests++; if (RegDataIn !== 32'd0) begin n_fail++; $display("FAIL rstmid_mem got %h exp 0", RegDataIn); end
        advance();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        m_pc = 32'd0; cur_rst = 1'b0;
        for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
        for (int k = 0; k < 64; k++) m_mem[k] = 32'd0;
        test_reset();
        test_xori();
        test_addi_hold();
        test_alu();
        test_mem();
        test_branch();
        test_x0_nop();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
